// File: rtl/vio_reg_bridge.sv
// -----------------------------------------------------------------------------
// vio_reg_bridge
//
// Register bridge between the ChipScope VIO core and the fabric. The VIO output
// bus is asynchronous to clk and is resynchronised here. A rising edge on one
// of the request bits becomes a single register read or write. Writes go to a
// bank of NREGS configuration words. Reads return a configuration word or a
// status word. Results go back to the VIO input bus.
//
// Handshake (software <-> bridge). Requests are level based, not valid/ready:
//   1. Software sets wdata and addr.
//   2. It waits at least 3 clk cycles, then raises exactly one of wr_req/rd_req.
//   3. The bridge executes once and then inverts ack_tgl. It also inverts
//      ack_tgl on an addressing error.
//   4. Software drops the req bit. The bridge accepts no new request until both
//      synchronised req bits have been seen low.
//   Raising both req bits in the same cycle counts as an error. It is not
//   acknowledged.
//
// Ports:
//   clk, rst     system clock; synchronous active-high reset
//   vio_out      {rd_req, wr_req, addr[7:0], wdata[DW-1:0]} from VIO (async)
//   status_in    NREGS read-only status words, word i at [i*DW +: DW] (clk domain)
//   cfg_regs     NREGS configuration words, word i at [i*DW +: DW]
//   cfg_wr_stb   one-cycle pulse per successful config write
//   cfg_wr_addr  address of the last successful write, held
//   vio_in       {err_cnt[5:0], busy, ack_tgl, rd_data[DW-1:0]} to VIO
//   dbg_state    current FSM state (IDLE=0, LATCH=1, EXEC=2, WAIT_LOW=3)
// -----------------------------------------------------------------------------
module vio_reg_bridge #(
  parameter int NREGS = 8,
  parameter int DW    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DW+9:0]       vio_out,
  input  logic [NREGS*DW-1:0] status_in,
  output logic [NREGS*DW-1:0] cfg_regs,
  output logic                cfg_wr_stb,
  output logic [7:0]          cfg_wr_addr,
  output logic [DW+7:0]       vio_in,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LATCH    = 2'd1,
    EXEC     = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

  localparam logic [7:0] NREGS_A  = 8'(NREGS);
  localparam logic [7:0] NREGS2_A = 8'(2 * NREGS);

  state_t state, state_nx;

  // Synchroniser stages and the previous value of the synchronised req bits.
  logic [DW+9:0] sync1, s2;
  logic [1:0]    s2_d;       // {rd, wr}
  logic [1:0]    req_s2;     // {rd, wr}
  logic [1:0]    rise;
  logic [1:0]    prime_cnt;
  logic          primed;

  // Fields latched from the synchronised bus when a request is accepted.
  logic [DW-1:0] lat_wdata;
  logic [7:0]    lat_addr;
  logic          lat_wr;

  logic [DW-1:0] cfg_q [NREGS];
  logic [DW-1:0] rd_data;
  logic          ack_tgl;
  logic [5:0]    err_cnt;

  // Decoded FSM actions.
  logic          capture, busy, err_inc;
  logic          exec_wr, exec_rd_cfg, exec_rd_sts;
  logic          addr_cfg, addr_sts;
  logic [DW-1:0] cfg_word, sts_word;

  assign req_s2 = s2[DW+9:DW+8];
  assign rise   = req_s2 & ~s2_d;

  // After reset the synchroniser still holds zeros. A request held high across
  // reset would look like "low, then rise". WAIT_LOW therefore waits until
  // real input values have reached s2 before it trusts a low level.
  assign primed = (prime_cnt == 2'd2);

  assign addr_cfg = (lat_addr < NREGS_A);
  assign addr_sts = (lat_addr >= NREGS_A) && (lat_addr < NREGS2_A);

  always_comb begin
    cfg_word = '0;
    sts_word = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (lat_addr == 8'(i))         cfg_word = cfg_q[i];
      if (lat_addr == 8'(NREGS + i)) sts_word = status_in[i*DW +: DW];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_LOW;
    else     state <= state_nx;
  end

  // Next state and decoded actions.
  always_comb begin
    state_nx    = state;
    capture     = 1'b0;
    busy        = 1'b0;
    err_inc     = 1'b0;
    exec_wr     = 1'b0;
    exec_rd_cfg = 1'b0;
    exec_rd_sts = 1'b0;
    case (state)
      IDLE: begin
        if (rise[0] ^ rise[1]) begin
          capture  = 1'b1;
          state_nx = LATCH;
        end else if (rise[0] & rise[1]) begin
          err_inc  = 1'b1;
          state_nx = WAIT_LOW;
        end
      end
      LATCH: begin
        busy     = 1'b1;
        state_nx = EXEC;
      end
      EXEC: begin
        busy     = 1'b1;
        state_nx = WAIT_LOW;
        if (lat_wr && addr_cfg)       exec_wr     = 1'b1;
        else if (!lat_wr && addr_cfg) exec_rd_cfg = 1'b1;
        else if (!lat_wr && addr_sts) exec_rd_sts = 1'b1;
        else                          err_inc     = 1'b1;
      end
      WAIT_LOW: begin
        if (primed && (req_s2 == 2'b00)) state_nx = IDLE;
      end
      default: state_nx = WAIT_LOW;
    endcase
  end

  // Datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= '0;
      s2          <= '0;
      s2_d        <= '0;
      prime_cnt   <= '0;
      lat_wdata   <= '0;
      lat_addr    <= '0;
      lat_wr      <= 1'b0;
      cfg_wr_addr <= '0;
      rd_data     <= '0;
      ack_tgl     <= 1'b0;
      err_cnt     <= '0;
      for (int i = 0; i < NREGS; i++) cfg_q[i] <= '0;
    end else begin
      sync1 <= vio_out;
      s2    <= sync1;
      s2_d  <= req_s2;
      if (!primed) prime_cnt <= prime_cnt + 2'd1;

      if (capture) begin
        lat_wdata <= s2[DW-1:0];
        lat_addr  <= s2[DW+7:DW];
        lat_wr    <= rise[0];
      end

      // The address is loaded on entry to EXEC so that it is already valid
      // while cfg_wr_stb is high.
      if (state == LATCH && lat_wr && addr_cfg) cfg_wr_addr <= lat_addr;

      if (state == EXEC) ack_tgl <= ~ack_tgl;

      if (exec_wr) begin
        rd_data <= lat_wdata;
        for (int i = 0; i < NREGS; i++)
          if (lat_addr == 8'(i)) cfg_q[i] <= lat_wdata;
      end else if (exec_rd_cfg) begin
        rd_data <= cfg_word;
      end else if (exec_rd_sts) begin
        rd_data <= sts_word;
      end

      if (err_inc && err_cnt != 6'd63) err_cnt <= err_cnt + 6'd1;
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_cfg
    assign cfg_regs[g*DW +: DW] = cfg_q[g];
  end

  assign cfg_wr_stb = exec_wr;
  assign vio_in     = {err_cnt, busy, ack_tgl, rd_data};
  assign dbg_state  = state;

endmodule

// File: tb/tb_vio_reg_bridge.sv
module tb_vio_reg_bridge;

  localparam int NREGS = 8;
  localparam int DW    = 16;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUT
  logic [DW-1:0]       wdata = '0;
  logic [7:0]          addr  = '0;
  logic                wr_req = 1'b0;
  logic                rd_req = 1'b0;
  logic [DW+9:0]       vio_out;
  logic [NREGS*DW-1:0] status_in;
  logic [NREGS*DW-1:0] cfg_regs;
  logic                cfg_wr_stb;
  logic [7:0]          cfg_wr_addr;
  logic [DW+7:0]       vio_in;
  logic [1:0]          dbg_state;

  assign vio_out = {rd_req, wr_req, addr, wdata};

  vio_reg_bridge #(.NREGS(NREGS), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .vio_out    (vio_out),
    .status_in  (status_in),
    .cfg_regs   (cfg_regs),
    .cfg_wr_stb (cfg_wr_stb),
    .cfg_wr_addr(cfg_wr_addr),
    .vio_in     (vio_in),
    .dbg_state  (dbg_state)
  );

  // ---------------------------------------------------------------- model
  logic [DW-1:0] m_cfg [NREGS];
  logic [DW-1:0] m_sts [NREGS];
  logic [DW-1:0] m_rd;
  logic          m_ack;
  int            m_err;
  logic [7:0]    exp_q[$];   // expected strobe addresses, in order
  logic [7:0]    obs_q[$];   // observed strobe addresses

  int checks = 0;
  int errors = 0;

  always_comb
    for (int i = 0; i < NREGS; i++) status_in[i*DW +: DW] = m_sts[i];

  always @(negedge clk)
    if (!rst && cfg_wr_stb) obs_q.push_back(cfg_wr_addr);

  function automatic logic [NREGS*DW-1:0] model_cfg();
    logic [NREGS*DW-1:0] v;
    for (int i = 0; i < NREGS; i++) v[i*DW +: DW] = m_cfg[i];
    return v;
  endfunction

  // The bus is idle whenever this is compared, so busy is expected low.
  function automatic logic [DW+7:0] model_vio();
    return {6'(m_err), 1'b0, m_ack, m_rd};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NREGS; i++) m_cfg[i] = '0;
    m_rd  = '0;
    m_ack = 1'b0;
    m_err = 0;
    exp_q.delete();
  endfunction

  function automatic void model_op(input bit wr, input bit rd,
                                   input logic [7:0] a, input logic [DW-1:0] d);
    if (wr && rd) begin
      if (m_err < 63) m_err++;
      return;
    end
    m_ack = ~m_ack;
    if (wr) begin
      if (a < NREGS) begin
        m_cfg[a] = d;
        m_rd     = d;
        exp_q.push_back(a);
      end else if (m_err < 63) m_err++;
    end else begin
      if (a < NREGS)          m_rd = m_cfg[a];
      else if (a < 2 * NREGS) m_rd = m_sts[a - NREGS];
      else if (m_err < 63)    m_err++;
    end
  endfunction

  // ---------------------------------------------------------------- drivers
  // Complete software transaction: set fields, wait, raise req(s) for `hold`
  // cycles, drop, and allow the bridge to return to IDLE.
  task automatic do_op(input bit wr, input bit rd, input logic [7:0] a,
                       input logic [DW-1:0] d, input int hold);
    @(negedge clk);
    wdata = d; addr = a; wr_req = 1'b0; rd_req = 1'b0;
    repeat (3) @(negedge clk);
    wr_req = wr; rd_req = rd;
    repeat (hold) @(negedge clk);
    wr_req = 1'b0; rd_req = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (6) @(negedge clk);
    checks++;
    if (cfg_regs !== '0) begin
      errors++; $display("FAIL reset_cfg: got %h expected 0", cfg_regs);
    end
    checks++;
    if (vio_in !== '0) begin
      errors++; $display("FAIL reset_vio_in: got %h expected 0", vio_in);
    end
    checks++;
    if (cfg_wr_stb !== 1'b0 || cfg_wr_addr !== 8'd0) begin
      errors++; $display("FAIL reset_stb: got stb=%b addr=%h expected 0/00", cfg_wr_stb, cfg_wr_addr);
    end
  endtask

  task automatic test_write_latency();
    logic ack0;
    ack0 = vio_in[DW];
    @(negedge clk);
    wdata = 16'hA5A5; addr = 8'd3;
    repeat (3) @(negedge clk);
    wr_req = 1'b1;                 // sampled at edge 1
    repeat (3) @(negedge clk);     // after edge 3: LATCH
    checks++;
    if (vio_in[DW+1] !== 1'b1 || cfg_wr_stb !== 1'b0) begin
      errors++; $display("FAIL latch_busy: got busy=%b stb=%b expected 1/0", vio_in[DW+1], cfg_wr_stb);
    end
    @(negedge clk);                // after edge 4: EXEC
    checks++;
    if (cfg_wr_stb !== 1'b1 || cfg_wr_addr !== 8'd3 || vio_in[DW] !== ack0) begin
      errors++; $display("FAIL exec_stb: got stb=%b addr=%h ack=%b expected 1/03/%b",
                         cfg_wr_stb, cfg_wr_addr, vio_in[DW], ack0);
    end
    checks++;
    if (cfg_regs[3*DW +: DW] !== 16'h0000) begin
      errors++; $display("FAIL early_write: got %h expected 0000", cfg_regs[3*DW +: DW]);
    end
    @(negedge clk);                // after edge 5: results visible
    model_op(1'b1, 1'b0, 8'd3, 16'hA5A5);
    checks++;
    if (cfg_wr_stb !== 1'b0 || vio_in[DW] !== ~ack0 || vio_in[DW+1] !== 1'b0) begin
      errors++; $display("FAIL post_exec: got stb=%b ack=%b busy=%b expected 0/%b/0",
                         cfg_wr_stb, vio_in[DW], vio_in[DW+1], ~ack0);
    end
    checks++;
    if (cfg_regs !== model_cfg()) begin
      errors++; $display("FAIL write_cfg: got %h expected %h", cfg_regs, model_cfg());
    end
    checks++;
    if (vio_in[DW-1:0] !== 16'hA5A5) begin
      errors++; $display("FAIL write_echo: got %h expected a5a5", vio_in[DW-1:0]);
    end
    wr_req = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (obs_q.size() != exp_q.size() || cfg_wr_addr !== 8'd3) begin
      errors++; $display("FAIL write_strobes: got %0d/%h expected %0d/03", obs_q.size(), cfg_wr_addr, exp_q.size());
    end
  endtask

  task automatic test_status_read();
    int n0;
    n0 = obs_q.size();
    do_op(1'b0, 1'b1, 8'(NREGS + 2), 16'hFFFF, 8);
    model_op(1'b0, 1'b1, 8'(NREGS + 2), 16'hFFFF);
    checks++;
    if (vio_in[DW-1:0] !== 16'h1234) begin
      errors++; $display("FAIL status_read: got %h expected 1234", vio_in[DW-1:0]);
    end
    checks++;
    if (vio_in !== model_vio() || obs_q.size() != n0) begin
      errors++; $display("FAIL status_vio: got %h strobes=%0d expected %h strobes=%0d",
                         vio_in, obs_q.size(), model_vio(), n0);
    end
    do_op(1'b0, 1'b1, 8'd3, 16'h0000, 8);
    model_op(1'b0, 1'b1, 8'd3, 16'h0000);
    checks++;
    if (vio_in[DW-1:0] !== 16'hA5A5 || vio_in !== model_vio()) begin
      errors++; $display("FAIL cfg_read: got %h expected %h", vio_in, model_vio());
    end
  endtask

  task automatic test_errors();
    logic [5:0] e0;
    logic       a0;
    e0 = vio_in[DW+7:DW+2];
    a0 = vio_in[DW];
    do_op(1'b1, 1'b0, 8'(NREGS), 16'hDEAD, 8);
    model_op(1'b1, 1'b0, 8'(NREGS), 16'hDEAD);
    do_op(1'b0, 1'b1, 8'(2 * NREGS), 16'h0000, 8);
    model_op(1'b0, 1'b1, 8'(2 * NREGS), 16'h0000);
    do_op(1'b1, 1'b1, 8'd1, 16'hBEEF, 8);
    model_op(1'b1, 1'b1, 8'd1, 16'hBEEF);
    checks++;
    if (vio_in[DW+7:DW+2] !== e0 + 6'd3) begin
      errors++; $display("FAIL err_cnt: got %0d expected %0d", vio_in[DW+7:DW+2], e0 + 6'd3);
    end
    checks++;
    if (vio_in[DW] !== a0 || vio_in !== model_vio()) begin
      errors++; $display("FAIL err_ack: got %h expected %h", vio_in, model_vio());
    end
    checks++;
    if (cfg_regs !== model_cfg() || obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL err_cfg: got %h expected %h", cfg_regs, model_cfg());
    end
  endtask

  task automatic test_held_request();
    int n0;
    n0 = obs_q.size();
    do_op(1'b1, 1'b0, 8'd5, 16'h1111, 50);
    model_op(1'b1, 1'b0, 8'd5, 16'h1111);
    checks++;
    if (obs_q.size() != n0 + 1 || vio_in !== model_vio()) begin
      errors++; $display("FAIL held_once: got strobes=%0d vio=%h expected %0d/%h",
                         obs_q.size() - n0, vio_in, 1, model_vio());
    end
    do_op(1'b1, 1'b0, 8'd5, 16'h2222, 8);
    model_op(1'b1, 1'b0, 8'd5, 16'h2222);
    checks++;
    if (obs_q.size() != n0 + 2 || cfg_regs !== model_cfg()) begin
      errors++; $display("FAIL held_rearm: got strobes=%0d cfg=%h expected %0d/%h",
                         obs_q.size() - n0, cfg_regs, 2, model_cfg());
    end
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    wdata = 16'h5A5A; addr = 8'd1;
    repeat (3) @(negedge clk);
    wr_req = 1'b1;
    repeat (3) @(negedge clk);     // in LATCH
    checks++;
    if (vio_in[DW+1] !== 1'b1) begin
      errors++; $display("FAIL abort_busy: got %b expected 1", vio_in[DW+1]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    obs_q.delete();
    checks++;
    if (cfg_regs !== '0 || vio_in !== '0 || cfg_wr_stb !== 1'b0 || cfg_wr_addr !== 8'd0) begin
      errors++; $display("FAIL abort_outputs: got cfg=%h vio=%h stb=%b addr=%h expected all 0",
                         cfg_regs, vio_in, cfg_wr_stb, cfg_wr_addr);
    end
    repeat (20) @(negedge clk);    // wr_req still high
    checks++;
    if (cfg_regs !== '0 || vio_in !== '0 || obs_q.size() != 0) begin
      errors++; $display("FAIL abort_held: got cfg=%h vio=%h strobes=%0d expected 0/0/0",
                         cfg_regs, vio_in, obs_q.size());
    end
    wr_req = 1'b0;
    repeat (4) @(negedge clk);
    do_op(1'b1, 1'b0, 8'd1, 16'h5A5A, 8);
    model_op(1'b1, 1'b0, 8'd1, 16'h5A5A);
    checks++;
    if (cfg_regs !== model_cfg() || vio_in !== model_vio() || obs_q.size() != 1) begin
      errors++; $display("FAIL abort_rearm: got cfg=%h vio=%h expected %h/%h",
                         cfg_regs, vio_in, model_cfg(), model_vio());
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int k;
      bit wr, rd;
      logic [7:0]    a;
      logic [DW-1:0] d;
      k  = $urandom_range(0, 9);
      wr = (k <= 5);
      rd = (k == 0) || (k >= 6);
      a  = 8'($urandom_range(0, 2 * NREGS + 3));
      d  = DW'($urandom);
      do_op(wr, rd, a, d, $urandom_range(6, 12));
      model_op(wr, rd, a, d);
      checks++;
      if (cfg_regs !== model_cfg() || vio_in !== model_vio() || obs_q.size() != exp_q.size()) begin
        errors++; $display("FAIL random_op%0d: got cfg=%h vio=%h strobes=%0d expected %h/%h/%0d",
                           n, cfg_regs, vio_in, obs_q.size(), model_cfg(), model_vio(), exp_q.size());
      end
    end
    checks++;
    if (obs_q != exp_q) begin
      errors++; $display("FAIL strobe_addrs: got %p expected %p", obs_q, exp_q);
    end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 70; n++) begin
      logic [7:0] a;
      a = 8'($urandom_range(NREGS, 255));
      do_op(1'b1, 1'b0, a, 16'hCAFE, 6);
      model_op(1'b1, 1'b0, a, 16'hCAFE);
    end
    checks++;
    if (vio_in[DW+7:DW+2] !== 6'd63 || vio_in !== model_vio()) begin
      errors++; $display("FAIL sat_err: got %h expected %h", vio_in, model_vio());
    end
    do_op(1'b0, 1'b1, 8'hFF, 16'h0000, 6);
    model_op(1'b0, 1'b1, 8'hFF, 16'h0000);
    checks++;
    if (vio_in[DW+7:DW+2] !== 6'd63 || cfg_regs !== model_cfg()) begin
      errors++; $display("FAIL sat_hold: got %0d expected 63", vio_in[DW+7:DW+2]);
    end
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    for (int i = 0; i < NREGS; i++) m_sts[i] = DW'($urandom);
    m_sts[2] = 16'h1234;
    model_reset();
    test_reset();
    test_write_latency();
    test_status_read();
    test_errors();
    test_held_request();
    test_reset_abort();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
